expr_vector_sequencer: RTL and testbench

- Controller that drives an expression datapath through a sequence of pseudo-random operand vectors.
- The datapath is a combinational block with 12 operands (a0..a5, b0..b5 at 4/5/6/4/5/6 bits) and a 90-bit result y.
- Per vector: load operands from an LFSR, wait a settle latency, sample y, fold it into a MISR signature.
- Sits between the regression harness (start/count/done) and the datapath under test; one signature per run.

---
 rtl/expr_seq_pkg.sv | 31 +++
 rtl/expr_seq_misr.sv | 38 +++
 rtl/expr_vector_sequencer.sv | 139 +++++++++++++
 tb/tb_expr_vector_sequencer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/expr_seq_pkg.sv
// expr_seq_pkg: shared types, LFSR taps, default widths and operand field offsets for expr_vector_sequencer
package expr_seq_pkg;

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CAPTURE, S_DONE} state_e;

    localparam logic [63:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

    localparam int DEF_OPW  = 60;
    localparam int DEF_RESW = 90;
    localparam int DEF_SIGW = 32;

    // LSB position of each operand inside op_vec (a0 at the MSB)
    localparam int A0_LSB = 56;
    localparam int A1_LSB = 51;
    localparam int A2_LSB = 45;
    localparam int A3_LSB = 41;
    localparam int A4_LSB = 36;
    localparam int A5_LSB = 30;
    localparam int B0_LSB = 26;
    localparam int B1_LSB = 21;
    localparam int B2_LSB = 15;
    localparam int B3_LSB = 11;
    localparam int B4_LSB = 6;
    localparam int B5_LSB = 0;

    // Galois right-shift step
    function automatic logic [63:0] lfsr_next(input logic [63:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/expr_seq_misr.sv
// expr_seq_misr: folds a RESW-bit result into SIGW bits and accumulates it with rotate-left XOR
// Ports: clk, rst_n (async active-low), clr_i (load zero, wins over en_i), en_i (accumulate y_i), y_i, sig_o
module expr_seq_misr
    import expr_seq_pkg::*;
#(
    parameter int RESW = DEF_RESW,
    parameter int SIGW = DEF_SIGW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr_i,
    input  logic            en_i,
    input  logic [RESW-1:0] y_i,
    output logic [SIGW-1:0] sig_o
);

    localparam int NCH  = (RESW + SIGW - 1) / SIGW;
    localparam int EXTW = NCH * SIGW;

    logic [EXTW-1:0] ext;
    logic [SIGW-1:0] fold;
    logic [SIGW-1:0] sig_q, sig_d;

    assign ext = EXTW'(y_i);

    always_comb begin
        fold = '0;
        for (int i = 0; i < NCH; i++) fold = fold ^ ext[i*SIGW +: SIGW];
        sig_d = clr_i ? '0 : en_i ? ({sig_q[SIGW-2:0], sig_q[SIGW-1]} ^ fold) : sig_q;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sig_q <= '0;
        else        sig_q <= sig_d;

    assign sig_o = sig_q;

endmodule

// File: rtl/expr_vector_sequencer.sv
// expr_vector_sequencer: drives an expression datapath with LFSR operand vectors and signs its results in a MISR
// Ports: clk, rst_n (async active-low), start, abort, vec_count -> run control;
//        op_vec -> operands to datapath, y_in <- datapath result;
//        busy, done, vec_cnt, signature -> run status/result.
// Optional (EXPR_SEQ_GOLDEN_CMP_EN): golden_y in, mismatch_cnt / first_fail / fail_seen out.
module expr_vector_sequencer
    import expr_seq_pkg::*;
#(
    parameter int          OPW  = DEF_OPW,
    parameter int          RESW = DEF_RESW,
    parameter int          SIGW = DEF_SIGW,
    parameter int          CNTW = 16,
    parameter int          LAT  = 1,
    parameter logic [63:0] SEED = 64'h0000_0000_0000_0001
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic [CNTW-1:0] vec_count,
    output logic [OPW-1:0]  op_vec,
    input  logic [RESW-1:0] y_in,
    output logic            busy,
    output logic            done,
    output logic [CNTW-1:0] vec_cnt,
    output logic [SIGW-1:0] signature
`ifdef EXPR_SEQ_GOLDEN_CMP_EN
    ,
    input  logic [RESW-1:0] golden_y,
    output logic [CNTW-1:0] mismatch_cnt,
    output logic [CNTW-1:0] first_fail,
    output logic            fail_seen
`endif
);

    localparam logic [3:0] WAIT_INIT = 4'(LAT - 1);

    state_e          state_q, state_d;
    logic [3:0]      wait_q, wait_d;
    logic [63:0]     lfsr_q, lfsr_d, lfsr_nx;
    logic [OPW-1:0]  op_q, op_d;
    logic [CNTW-1:0] cnt_q, cnt_d, len_q, len_d, cnt_inc;
    logic            accept, run, cap;

    assign lfsr_nx = lfsr_next(lfsr_q);
    assign cnt_inc = cnt_q + 1'b1;

    // abort overrides every transition, including a start in IDLE/DONE
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        accept  = 1'b0;
        cap     = 1'b0;
        if (abort) state_d = S_IDLE;
        else begin
            case (state_q)
                S_IDLE, S_DONE: if (start) begin
                    accept  = 1'b1;
                    state_d = (vec_count == '0) ? S_DONE : S_SETTLE;
                    wait_d  = WAIT_INIT;
                end
                S_SETTLE: begin
                    state_d = (wait_q == '0) ? S_CAPTURE : S_SETTLE;
                    wait_d  = (wait_q == '0) ? wait_q : wait_q - 1'b1;
                end
                S_CAPTURE: begin
                    cap     = 1'b1;
                    state_d = (cnt_inc == len_q) ? S_DONE : S_SETTLE;
                    wait_d  = WAIT_INIT;
                end
                default: state_d = S_IDLE;
            endcase
        end
        run    = accept && (vec_count != '0);
        lfsr_d = run ? SEED : cap ? lfsr_nx : lfsr_q;
        op_d   = run ? SEED[OPW-1:0] : cap ? lfsr_nx[OPW-1:0] : op_q;
        cnt_d  = accept ? '0 : cap ? cnt_inc : cnt_q;
        len_d  = accept ? vec_count : len_q;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
            lfsr_q  <= SEED;
            op_q    <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            lfsr_q  <= lfsr_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
        end

    expr_seq_misr #(.RESW(RESW), .SIGW(SIGW)) u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (accept),
        .en_i  (cap),
        .y_i   (y_in),
        .sig_o (signature)
    );

    assign op_vec  = op_q;
    assign vec_cnt = cnt_q;
    assign busy    = (state_q == S_SETTLE) || (state_q == S_CAPTURE);
    assign done    = (state_q == S_DONE);

`ifdef EXPR_SEQ_GOLDEN_CMP_EN
    logic [CNTW-1:0] mm_q, mm_d, ff_q, ff_d;
    logic            seen_q, seen_d, miss;

    always_comb begin
        miss   = cap && (y_in != golden_y);
        mm_d   = accept ? '0 : miss ? mm_q + 1'b1 : mm_q;
        ff_d   = accept ? '0 : (miss && !seen_q) ? cnt_q : ff_q;
        seen_d = accept ? 1'b0 : seen_q | miss;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            mm_q   <= '0;
            ff_q   <= '0;
            seen_q <= 1'b0;
        end else begin
            mm_q   <= mm_d;
            ff_q   <= ff_d;
            seen_q <= seen_d;
        end

    assign mismatch_cnt = mm_q;
    assign first_fail   = ff_q;
    assign fail_seen    = seen_q;
`endif

endmodule

// File: tb/tb_expr_vector_sequencer.sv
// tb_expr_vector_sequencer: directed self-checking bench for expr_vector_sequencer
module tb_expr_vector_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] vec_count = '0;
    logic [59:0] op_vec;
    logic [89:0] y_in = '0;
    logic        busy, done;
    logic [15:0] vec_cnt;
    logic [31:0] signature;
`ifdef EXPR_SEQ_GOLDEN_CMP_EN
    logic [89:0] golden_y = '0;
    logic [15:0] mismatch_cnt, first_fail;
    logic        fail_seen;
`endif

    int checks = 0;
    int errs   = 0;

    always #5 clk = ~clk;

    expr_vector_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .vec_count (vec_count),
        .op_vec    (op_vec),
        .y_in      (y_in),
        .busy      (busy),
        .done      (done),
        .vec_cnt   (vec_cnt),
        .signature (signature)
`ifdef EXPR_SEQ_GOLDEN_CMP_EN
        ,
        .golden_y     (golden_y),
        .mismatch_cnt (mismatch_cnt),
        .first_fail   (first_fail),
        .fail_seen    (fail_seen)
`endif
    );

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [15:0] n);
        vec_count = n;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, " op_vec"}, 96'(op_vec), 96'd0);
        check({tag, " busy"}, 96'(busy), 96'd0);
        check({tag, " done"}, 96'(done), 96'd0);
        check({tag, " vec_cnt"}, 96'(vec_cnt), 96'd0);
        check({tag, " sig"}, 96'(signature), 96'd0);
    endtask

    initial begin
        #12;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // zero-length run: straight to DONE
        go(16'd0);
        check("n0 done", 96'(done), 96'd1);
        check("n0 busy", 96'(busy), 96'd0);
        check("n0 sig", 96'(signature), 96'd0);
        check("n0 vec_cnt", 96'(vec_cnt), 96'd0);
        tick();
        check("n0 busy hold", 96'(busy), 96'd0);

        // single vector, y=0
        y_in = '0;
        go(16'd1);
        check("n1 busy", 96'(busy), 96'd1);
        check("n1 op_vec", 96'(op_vec), 96'h1);
        tick();
        check("n1 done early", 96'(done), 96'd0);
        tick();
        check("n1 done", 96'(done), 96'd1);
        check("n1 sig", 96'(signature), 96'd0);
        check("n1 vec_cnt", 96'(vec_cnt), 96'd1);

        // two vectors, y=all ones
        y_in = '1;
        go(16'd2);
        tick();
        tick();
        check("n2 sig v1", 96'(signature), 96'h03FF_FFFF);
        check("n2 vec_cnt v1", 96'(vec_cnt), 96'd1);
        check("n2 op_vec v2", 96'(op_vec), 96'h800_0000_0000_0000);
        tick();
        tick();
        check("n2 done", 96'(done), 96'd1);
        check("n2 sig v2", 96'(signature), 96'h0400_0001);
        check("n2 vec_cnt v2", 96'(vec_cnt), 96'd2);

        // abort in the third SETTLE of a 5-vector run
        go(16'd5);
        repeat (4) tick();
        check("ab busy pre", 96'(busy), 96'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab busy", 96'(busy), 96'd0);
        check("ab done", 96'(done), 96'd0);
        check("ab vec_cnt", 96'(vec_cnt), 96'd2);
        check("ab sig", 96'(signature), 96'h0400_0001);
        check("ab op_vec", 96'(op_vec), 96'hC00_0000_0000_0000);
        y_in = '0;
        go(16'd1);
        check("re op_vec", 96'(op_vec), 96'h1);
        check("re sig", 96'(signature), 96'd0);
        check("re vec_cnt", 96'(vec_cnt), 96'd0);
        tick();
        tick();
        check("re done", 96'(done), 96'd1);
        check("re vec_cnt end", 96'(vec_cnt), 96'd1);

        // start during busy is ignored
        go(16'd2);
        vec_count = 16'd7;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        tick();
        tick();
        check("sb done early", 96'(done), 96'd0);
        tick();
        check("sb done", 96'(done), 96'd1);
        check("sb vec_cnt", 96'(vec_cnt), 96'd2);

        // abort beats start in DONE
        vec_count = 16'd3;
        start     = 1'b1;
        abort     = 1'b1;
        tick();
        start     = 1'b0;
        abort     = 1'b0;
        check("sa done", 96'(done), 96'd0);
        check("sa busy", 96'(busy), 96'd0);

        // async reset in CAPTURE
        y_in = '1;
        go(16'd3);
        tick();
        check("rc busy", 96'(busy), 96'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("rst mid");
        @(negedge clk);
        rst_n = 1'b1;
        #1;

`ifdef EXPR_SEQ_GOLDEN_CMP_EN
        y_in     = 90'h155_5555_5555_5555_5555_5555;
        golden_y = y_in;
        go(16'd4);
        repeat (5) tick();
        golden_y = ~y_in;
        tick();
        golden_y = y_in;
        tick();
        tick();
        check("g done", 96'(done), 96'd1);
        check("g mismatch_cnt", 96'(mismatch_cnt), 96'd1);
        check("g first_fail", 96'(first_fail), 96'd2);
        check("g fail_seen", 96'(fail_seen), 96'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
